// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: fetch-to-decode packet types shared by inst_queue and its storage
package inst_queue_pkg;
  typedef enum logic [3:0] {
    EXC_NONE = 4'd0, EXC_INT, EXC_ADEF, EXC_TLBR, EXC_PIF, EXC_PPI, EXC_INE, EXC_SYS, EXC_BRK
  } exception_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        have_exception;
    exception_t  exception_type;
    logic        pred_branch_taken;
    logic [31:0] pred_branch_target;
  } if_packet_t;
endpackage

// File: rtl/inst_queue_iq_ram.sv
// iq_ram: DEPTH-entry packet register file, one synchronous write port, one asynchronous read port
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  if_packet_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output if_packet_t    o_rdata
);
  if_packet_t r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/inst_queue.sv
// inst_queue: fetch/decode decoupling FIFO with one-cycle flush; INST_QUEUE_BYPASS_EN adds empty-queue bypass
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_have_exception,
  input  exception_t               in_exception_type,
  input  logic                     in_pred_branch_taken,
  input  logic [31:0]              in_pred_branch_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_have_exception,
  output exception_t               out_exception_type,
  output logic                     out_pred_branch_taken,
  output logic [31:0]              out_pred_branch_target,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  if_packet_t    w_in_pkt, w_rd_pkt, w_out_pkt;
  logic          w_bypass, w_push, w_pop, w_wr, w_rd;
  assign w_in_pkt = '{pc: in_pc, inst: in_inst, have_exception: in_have_exception,
                      exception_type: in_exception_type, pred_branch_taken: in_pred_branch_taken,
                      pred_branch_target: in_pred_branch_target};
`ifdef INST_QUEUE_BYPASS_EN
  assign w_bypass = (r_count == '0) && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif
  assign in_ready  = r_count != FULL;
  assign out_valid = (r_count != '0) || w_bypass;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // a bypassed packet that is consumed immediately never touches storage
  assign w_wr      = w_push && !(w_bypass && out_ready);
  assign w_rd      = w_pop && !w_bypass;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  iq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr && !flush),
    .i_waddr (r_wptr),
    .i_wdata (w_in_pkt),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_pkt)
  );
  assign w_out_pkt              = w_bypass ? w_in_pkt : w_rd_pkt;
  assign out_pc                 = w_out_pkt.pc;
  assign out_inst               = w_out_pkt.inst;
  assign out_have_exception     = w_out_pkt.have_exception;
  assign out_exception_type     = w_out_pkt.exception_type;
  assign out_pred_branch_taken  = w_out_pkt.pred_branch_taken;
  assign out_pred_branch_target = w_out_pkt.pred_branch_target;
  assign count                  = r_count;
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed + random stimulus for inst_queue checked against a packet-queue model
module tb_inst_queue;
  import inst_queue_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0, resetn = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  if_packet_t in_pkt = '0;
  logic in_ready, out_valid, out_have_exception, out_pred_branch_taken;
  logic [31:0] out_pc, out_inst, out_pred_branch_target;
  exception_t out_exception_type;
  logic [$clog2(DEPTH):0] count;
  if_packet_t q[$];
  int checks = 0, passes = 0, sent;
  bit last_push, tog;
  exception_t exc_tab[4] = '{EXC_NONE, EXC_ADEF, EXC_TLBR, EXC_PIF};

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pkt.pc), .in_inst(in_pkt.inst), .in_have_exception(in_pkt.have_exception),
    .in_exception_type(in_pkt.exception_type), .in_pred_branch_taken(in_pkt.pred_branch_taken),
    .in_pred_branch_target(in_pkt.pred_branch_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_have_exception(out_have_exception),
    .out_exception_type(out_exception_type), .out_pred_branch_taken(out_pred_branch_taken),
    .out_pred_branch_target(out_pred_branch_target), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic if_packet_t rnd_pkt(input logic [31:0] pc);
    if_packet_t p;
    p.pc = pc;
    p.inst = $urandom;
    p.have_exception = 1'($urandom_range(0, 1));
    p.exception_type = exc_tab[$urandom_range(0, 3)];
    p.pred_branch_taken = 1'($urandom_range(0, 1));
    p.pred_branch_target = $urandom;
    return p;
  endfunction

  // one clock: check outputs against the model, then let the model take the edge
  task automatic step();
    bit bp, push, pop, cons, vld;
    if_packet_t head, got;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    bp = q.size() == 0 && in_valid && !flush;
`else
    bp = 1'b0;
`endif
    vld = q.size() != 0 || bp;
    head = q.size() != 0 ? q[0] : in_pkt;
    chk("count", 128'(count), 128'(q.size()));
    chk("in_ready", 128'(in_ready), 128'(q.size() != DEPTH));
    chk("out_valid", 128'(out_valid), 128'(vld));
    if (vld) begin
      got = '{pc: out_pc, inst: out_inst, have_exception: out_have_exception,
              exception_type: out_exception_type, pred_branch_taken: out_pred_branch_taken,
              pred_branch_target: out_pred_branch_target};
      chk("head", 128'(got), 128'(head));
    end
    push = in_valid && q.size() != DEPTH;
    pop  = vld && out_ready;
    cons = pop && q.size() == 0;
    last_push = push && !flush;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop && !cons) void'(q.pop_front());
      if (push && !cons) q.push_back(in_pkt);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    #1 resetn = 1'b0;
    #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    resetn = 1'b1;
    // fill then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      out_ready = 1'b0;
      in_pkt = rnd_pkt(32'h1c000000 + 32'(4 * i));
      step();
    end
    in_valid = 1'b0;
    step();
    drain();
    // full with simultaneous pop: push refused, retried next cycle
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      out_ready = 1'b0;
      in_pkt = rnd_pkt(32'h1c000100 + 32'(4 * i));
      step();
    end
    in_pkt = rnd_pkt(32'h1c000200);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    step();
    drain();
    // wrap-around stream with toggling out_ready
    sent = 0;
    tog = 1'b1;
    while (sent < 20) begin
      in_valid = 1'b1;
      in_pkt = rnd_pkt(32'h1c001000 + 32'(4 * sent));
      out_ready = tog;
      step();
      if (last_push) sent++;
      tog = !tog;
    end
    drain();
    // flush at count=5 with concurrent push and pop
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      out_ready = 1'b0;
      in_pkt = rnd_pkt(32'h1c002000 + 32'(4 * i));
      step();
    end
    flush = 1'b1;
    out_ready = 1'b1;
    in_pkt = rnd_pkt(32'h1c0020f0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    in_pkt = rnd_pkt(32'h1c003000);
    step();
    drain();
    // field integrity
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_pkt = '{pc: 32'h1c000020, inst: 32'h02bffc63, have_exception: 1'b1, exception_type: EXC_ADEF,
               pred_branch_taken: 1'b1, pred_branch_target: 32'h1c000040};
    step();
    in_valid = 1'b0;
    step();
    drain();
    // random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 29) == 0);
      in_pkt = rnd_pkt($urandom);
      step();
    end
    drain();
    // asynchronous reset mid-cycle at count=3
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      out_ready = 1'b0;
      in_pkt = rnd_pkt(32'h1c004000 + 32'(4 * i));
      step();
    end
    in_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("async_count", 128'(count), 128'(0));
    chk("async_out_valid", 128'(out_valid), 128'(0));
    q.delete();
    #1 resetn = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_pkt = rnd_pkt(32'h1c005000);
    step();
    in_valid = 1'b0;
    step();
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
